// File: rtl/clk_sel_pkg.sv
// Shared encodings, FSM state type and source-priority helper for the clock-select sequencer.
package clk_sel_pkg;

    localparam logic [1:0] SEL_CLK1 = 2'b00;
    localparam logic [1:0] SEL_CLK2 = 2'b01;
    localparam logic [1:0] SEL_CLK3 = 2'b10;
    localparam logic [1:0] SEL_BAD  = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Lowest-index healthy source; SEL_BAD when nothing is healthy.
    function automatic logic [1:0] lowest_ok(input logic [2:0] ok);
        if (ok[0]) return SEL_CLK1;
        if (ok[1]) return SEL_CLK2;
        if (ok[2]) return SEL_CLK3;
        return SEL_BAD;
    endfunction

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// Request handshake, health flags and mux-side status of the clock-select sequencer.
interface clk_sel_ctrl_if;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [2:0] clk_ok;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       err;
    logic       fail_evt;
    logic       no_clk;

    modport master (
        output req_valid, req_sel, clk_ok,
        input  req_ready, sel, busy, done, err, fail_evt, no_clk
    );

    modport slave (
        input  req_valid, req_sel, clk_ok,
        output req_ready, sel, busy, done, err, fail_evt, no_clk
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, asynchronously cleared to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clk_sel_ctrl.sv
// Clock-select sequencer driving the glitch-free mux select with a settle hold-off.
// Automatic failover away from a dead source is built when CLK_SEL_FAILOVER_EN is defined.
//
// state     | meaning
// ST_IDLE   | sel stable, requests (or failover) may start a switch
// ST_SETTLE | sel just changed, holding it while the mux handshakes
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int         SETTLE_CYC = 16,
    parameter logic [1:0] RST_SEL    = SEL_CLK1
) (
    input  logic           clk,
    input  logic           rst,
    clk_sel_ctrl_if.slave  bus
);
    localparam int CW = $clog2(SETTLE_CYC + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    ok_s;
    logic [3:0]    ok_ext;
    logic [1:0]    sel_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          fail_q;
    logic          no_clk_q;
    logic          fo_start;
    logic [1:0]    fo_sel;
    logic          req_bad;

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        sync_2ff u_sync (
            .clk (clk),
            .rst (rst),
            .d   (bus.clk_ok[gi]),
            .q   (ok_s[gi])
        );
    end

    // Pad so a 2-bit select can index health safely; the illegal code reads as unhealthy.
    assign ok_ext  = {1'b0, ok_s};
    assign req_bad = (bus.req_sel == SEL_BAD) || !ok_ext[bus.req_sel];

`ifdef CLK_SEL_FAILOVER_EN
    // |ok_s covers the cycle where ok_s has just emptied but registered no_clk still lags.
    assign fo_sel   = lowest_ok(ok_s);
    assign fo_start = (state == ST_IDLE) && !ok_ext[sel_q] && !no_clk_q && (|ok_s);
`else
    assign fo_sel   = SEL_CLK1;
    assign fo_start = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel_q    <= RST_SEL;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= 1'b0;
            no_clk_q <= 1'b1;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            fail_q   <= 1'b0;
            no_clk_q <= ~|ok_s;
            case (state)
                ST_IDLE: begin
                    if (fo_start) begin
                        sel_q  <= fo_sel;
                        cnt    <= CW'(SETTLE_CYC);
                        busy_q <= 1'b1;
                        fail_q <= 1'b1;
                        state  <= ST_SETTLE;
                    end else if (bus.req_valid) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else if (bus.req_sel == sel_q) begin
                            done_q <= 1'b1;
                        end else begin
                            sel_q  <= bus.req_sel;
                            cnt    <= CW'(SETTLE_CYC);
                            busy_q <= 1'b1;
                            state  <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE) && !fo_start;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.fail_evt  = fail_q;
    assign bus.no_clk    = no_clk_q;
endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl with SETTLE_CYC=4; failover steps follow CLK_SEL_FAILOVER_EN.
module tb_clk_sel_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    clk_sel_ctrl_if bus ();

    clk_sel_ctrl #(.SETTLE_CYC(4), .RST_SEL(2'b00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_sel   = 2'b00;
        bus.clk_ok    = 3'b111;

        // Reset with all clocks healthy: synchronizers stay cleared.
        tick();
        tick();
        chk("rst_sel",    bus.sel, 2'b00);
        chk("rst_ready",  bus.req_ready, 1'b1);
        chk("rst_busy",   bus.busy, 1'b0);
        chk("rst_done",   bus.done, 1'b0);
        chk("rst_no_clk", bus.no_clk, 1'b1);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("no_clk_clear", bus.no_clk, 1'b0);

        // Legal switch 00 -> 10.
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b10;
        chk("sw_ready_pre", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        chk("sw_sel",   bus.sel, 2'b10);
        chk("sw_busy0", bus.busy, 1'b1);
        chk("sw_ready", bus.req_ready, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("sw_busy", bus.busy, 1'b1);
            chk("sw_nodone", bus.done, 1'b0);
        end
        tick();
        chk("sw_done",      bus.done, 1'b1);
        chk("sw_busy_end",  bus.busy, 1'b0);
        chk("sw_ready_end", bus.req_ready, 1'b1);
        tick();
        chk("sw_done_pulse", bus.done, 1'b0);

        // Illegal code 11.
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b11;
        tick();
        bus.req_valid = 1'b0;
        chk("bad_err",   bus.err, 1'b1);
        chk("bad_sel",   bus.sel, 2'b10);
        chk("bad_ready", bus.req_ready, 1'b1);
        chk("bad_busy",  bus.busy, 1'b0);
        tick();
        chk("bad_err_pulse", bus.err, 1'b0);

        // Unhealthy target clk2.
        bus.clk_ok = 3'b101;
        tick();
        tick();
        tick();
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b01;
        tick();
        bus.req_valid = 1'b0;
        chk("sick_err",  bus.err, 1'b1);
        chk("sick_sel",  bus.sel, 2'b10);
        chk("sick_done", bus.done, 1'b0);

        // Same-source request.
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b10;
        tick();
        bus.req_valid = 1'b0;
        chk("same_done", bus.done, 1'b1);
        chk("same_busy", bus.busy, 1'b0);
        chk("same_err",  bus.err, 1'b0);
        chk("same_sel",  bus.sel, 2'b10);

        // Held-off request: second request kept valid through SETTLE.
        bus.clk_ok = 3'b111;
        tick();
        tick();
        tick();
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b00;
        tick();
        bus.req_sel   = 2'b01;
        chk("hold_sel0", bus.sel, 2'b00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("hold_ready", bus.req_ready, 1'b0);
            chk("hold_sel",   bus.sel, 2'b00);
        end
        tick();
        chk("hold_done",    bus.done, 1'b1);
        chk("hold_ready1",  bus.req_ready, 1'b1);
        chk("hold_sel_idle", bus.sel, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        chk("hold_accept", bus.sel, 2'b01);
        chk("hold_busy",   bus.busy, 1'b1);
        tick();
        tick();
        tick();
        chk("hold_busy_last", bus.busy, 1'b1);
        tick();
        chk("hold_done2", bus.done, 1'b1);

        // Reset in the middle of SETTLE (counter at 2).
        tick();
        bus.req_valid = 1'b1;
        bus.req_sel   = 2'b10;
        tick();
        bus.req_valid = 1'b0;
        chk("mid_sel_pre", bus.sel, 2'b10);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_sel_rst",  bus.sel, 2'b00);
        chk("mid_busy_rst", bus.busy, 1'b0);
        chk("mid_ready",    bus.req_ready, 1'b1);
        tick();
        chk("mid_no_done", bus.done, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_no_done2", bus.done, 1'b0);
        chk("mid_sel_hold", bus.sel, 2'b00);
        tick();
        tick();
        chk("mid_no_clk", bus.no_clk, 1'b0);

`ifdef CLK_SEL_FAILOVER_EN
        // clk1 dies: failover to clk2 three edges after the drop.
        bus.clk_ok = 3'b110;
        tick();
        tick();
        chk("fo_not_yet", bus.fail_evt, 1'b0);
        chk("fo_sel_pre", bus.sel, 2'b00);
        tick();
        chk("fo_evt",   bus.fail_evt, 1'b1);
        chk("fo_sel",   bus.sel, 2'b01);
        chk("fo_busy",  bus.busy, 1'b1);
        tick();
        chk("fo_evt_pulse", bus.fail_evt, 1'b0);
        tick();
        tick();
        tick();
        chk("fo_done", bus.done, 1'b1);
        bus.clk_ok = 3'b000;
        tick();
        tick();
        tick();
        chk("fo_no_clk",  bus.no_clk, 1'b1);
        chk("fo_hold",    bus.sel, 2'b01);
        chk("fo_no_evt",  bus.fail_evt, 1'b0);
        tick();
        tick();
        chk("fo_hold2",   bus.sel, 2'b01);
        chk("fo_no_busy", bus.busy, 1'b0);
`else
        // Without failover a dead clk1 leaves sel alone.
        bus.clk_ok = 3'b110;
        tick();
        tick();
        tick();
        tick();
        chk("nofo_evt",  bus.fail_evt, 1'b0);
        chk("nofo_sel",  bus.sel, 2'b00);
        chk("nofo_busy", bus.busy, 1'b0);
        bus.clk_ok = 3'b000;
        tick();
        tick();
        tick();
        chk("nofo_no_clk", bus.no_clk, 1'b1);
        chk("nofo_hold",   bus.sel, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
